// File: rtl/fir_seq_ctrl_if.sv
// Sample-strobe and queue-output bundle between the audio front end,
// fir_seq_ctrl (slave) and the downstream FIR datapath.
interface fir_seq_ctrl_if;
  logic               wrt_smpl;
  logic signed [15:0] lft_in;
  logic signed [15:0] rght_in;
  logic               sequencing;
  logic signed [15:0] lft_smpl;
  logic signed [15:0] rght_smpl;
  logic               done;
  logic               overrun;

  modport master (
    output wrt_smpl, lft_in, rght_in,
    input  sequencing, lft_smpl, rght_smpl, done, overrun
  );

  modport slave (
    input  wrt_smpl, lft_in, rght_in,
    output sequencing, lft_smpl, rght_smpl, done, overrun
  );
endinterface

// File: rtl/fir_seq_ctrl.sv
// Stereo circular sample queue that replays the DEPTH newest samples, oldest
// first, to a FIR on every new strobe. Define SEQ_OVERRUN_DET_EN for overrun.
module fir_seq_ctrl #(
  parameter int DEPTH = 1021
) (
  input  logic          clk,
  input  logic          rst,
  fir_seq_ctrl_if.slave bus
);
  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [9:0]  LAST    = 10'(DEPTH - 1);
  localparam logic [10:0] CNT_MAX = 11'(DEPTH);

  localparam logic [1:0] FILL = 2'd0;
  localparam logic [1:0] IDLE = 2'd1;
  localparam logic [1:0] SEQ  = 2'd2;

  logic [1:0]         state;
  logic [9:0]         new_ptr;
  logic [9:0]         old_ptr;
  logic [9:0]         rd_ptr;
  logic [10:0]        cnt;
  logic               sequencing;
  logic               done;
  logic signed [15:0] lft_smpl;
  logic signed [15:0] rght_smpl;
  logic               wr_en;
  logic               start;
  logic               last;

  logic signed [15:0] lft_q  [DEPTH];
  logic signed [15:0] rght_q [DEPTH];

  // Wrap at DEPTH-1 so non-power-of-two depths stay contiguous.
  function automatic logic [9:0] nxt(input logic [9:0] p);
    return (p == LAST) ? '0 : p + 10'd1;
  endfunction

  always_comb begin
    wr_en = 1'b0;
    start = 1'b0;
    last  = 1'b0;
    case (state)
      FILL: wr_en = bus.wrt_smpl;
      IDLE: begin
        // A strobe landing on the done cycle belongs to the finished pass.
        start = bus.wrt_smpl && !done;
        wr_en = start;
      end
      SEQ:     last = (cnt == CNT_MAX);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      lft_q[new_ptr[AW-1:0]]  <= bus.lft_in;
      rght_q[new_ptr[AW-1:0]] <= bus.rght_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= FILL;
      new_ptr    <= '0;
      old_ptr    <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      sequencing <= 1'b0;
      done       <= 1'b0;
      lft_smpl   <= '0;
      rght_smpl  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        FILL: begin
          if (bus.wrt_smpl) begin
            new_ptr <= nxt(new_ptr);
            if (cnt == CNT_MAX - 11'd1) begin
              cnt   <= '0;
              state <= IDLE;
            end else begin
              cnt <= cnt + 11'd1;
            end
          end
        end
        IDLE: begin
          if (start) begin
            new_ptr    <= nxt(new_ptr);
            old_ptr    <= nxt(old_ptr);
            rd_ptr     <= nxt(old_ptr);
            cnt        <= '0;
            sequencing <= 1'b1;
            state      <= SEQ;
          end
        end
        SEQ: begin
          if (last) begin
            sequencing <= 1'b0;
            done       <= 1'b1;
            cnt        <= '0;
            state      <= IDLE;
          end else begin
            // Registered read: cycle k+1 shows the sample fetched in cycle k.
            cnt       <= cnt + 11'd1;
            rd_ptr    <= nxt(rd_ptr);
            lft_smpl  <= lft_q[rd_ptr[AW-1:0]];
            rght_smpl <= rght_q[rd_ptr[AW-1:0]];
          end
        end
        default: state <= FILL;
      endcase
    end
  end

`ifdef SEQ_OVERRUN_DET_EN
  logic overrun;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (bus.wrt_smpl && ((state == SEQ) || done)) begin
      overrun <= 1'b1;
    end
  end

  assign bus.overrun = overrun;
`else
  assign bus.overrun = 1'b0;
`endif

  assign bus.sequencing = sequencing;
  assign bus.done       = done;
  assign bus.lft_smpl   = lft_smpl;
  assign bus.rght_smpl  = rght_smpl;
endmodule

// File: doc/fir_seq_ctrl.md
FIR_SEQ_CTRL -- requirements
Module: fir_seq_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 1021, meaning the number of taps and the number of queue entries (legal range 4..1024).
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-004 SHALL have port wrt_smpl  input  1  single-cycle strobe; a new stereo sample pair is present.
REQ-005 SHALL have port lft_in  input  16  signed left sample, captured when wrt_smpl=1.
REQ-006 SHALL have port rght_in  input  16  signed right sample, captured when wrt_smpl=1.
REQ-007 SHALL have port sequencing  output  1  high while the downstream FIR steps its coefficient ROM and MAC.
REQ-008 SHALL have port lft_smpl  output  16  signed left queue sample presented to the FIR.
REQ-009 SHALL have port rght_smpl  output  16  signed right queue sample presented to the FIR.
REQ-010 SHALL have port done  output  1  one-cycle pulse when a convolution pass ends.
REQ-011 SHALL have port overrun  output  1  sticky flag: wrt_smpl arrived during a pass.

Function
REQ-012 SHALL hold two internal DEPTH x 16 circular queues (left, right), sharing one 10-bit write pointer new_ptr and one oldest pointer old_ptr.
REQ-013 SHALL implement states FILL, IDLE, SEQ.
REQ-014 FILL: each wrt_smpl writes at new_ptr and increments it; when DEPTH entries are held, go to IDLE; sequencing stays 0.
REQ-015 IDLE + wrt_smpl: write the sample at new_ptr, advance new_ptr and old_ptr (oldest entry overwritten), load rd_ptr with the updated old_ptr, go to SEQ.
REQ-016 SEQ: sequencing=1 for exactly DEPTH+1 consecutive cycles, starting the cycle after entry.
REQ-017 SEQ: rd_ptr increments once per cycle for DEPTH reads; the queue read is registered, so sample k (k=0 oldest) appears on lft_smpl/rght_smpl in sequencing cycle k+1, matching the FIR one-cycle ROM latency.
REQ-018 Cycle 0 of sequencing SHALL present a don't-care sample; the FIR clears its accumulator in that cycle.
REQ-019 All pointers SHALL wrap from DEPTH-1 to 0; wrap is a compare against DEPTH-1, never a power-of-two rollover.
REQ-020 After the last sequencing cycle: sequencing=0, done=1 for one cycle, return to IDLE.
REQ-021 wrt_smpl in SEQ SHALL be ignored (no write, no pointer change) and SHALL set overrun.
REQ-022 wrt_smpl on the same cycle as done SHALL be ignored and SHALL set overrun.
REQ-023 lft_smpl/rght_smpl SHALL hold their last value outside SEQ.

Reset
REQ-024 rst=1 SHALL immediately force state=FILL, new_ptr=old_ptr=rd_ptr=0, sequencing=0, done=0, overrun=0, lft_smpl=rght_smpl=0.
REQ-025 Reset mid-pass SHALL abort the pass with no done pulse; queue contents are not cleared but are treated as empty.

Configuration
REQ-026 Macro SEQ_OVERRUN_DET_EN: defined -> overrun behaves per REQ-021/022 and clears only on rst.
REQ-027 Macro SEQ_OVERRUN_DET_EN: undefined -> overrun tied 0 and no overrun logic is present; the ignore behaviour of REQ-021/022 is unchanged.

Verification
REQ-028 DEPTH=8, write samples 1..8 -> sequencing stays 0 throughout; state reaches IDLE after the 8th strobe.
REQ-029 DEPTH=8 after fill, write sample 9 -> sequencing high 9 cycles; lft_smpl shows 2,3,...,9 on cycles 1..8; done pulses 1 cycle after the last.
REQ-030 DEPTH=8, 20 strobes spaced 12 cycles apart -> each pass presents the 8 newest samples oldest-first; pointers wrap correctly (7 -> 0).
REQ-031 Strobe at sequencing cycle 4, with SEQ_OVERRUN_DET_EN defined -> queue unchanged, overrun=1 and held; without the macro -> overrun=0.
REQ-032 rst asserted at sequencing cycle 5 -> sequencing=0 and done=0 in the same cycle; the next 8 strobes refill with no pass.
REQ-033 DEPTH=1021, rght_in=-32768 and lft_in=32767 streamed -> sequencing width 1022 cycles; outputs are sign-correct.
